// File: rtl/seg_led_ascii_mux.sv
// Multiplexed ASCII seven-segment driver: double-buffered digit data, slot-based
// scan with 16-level PWM brightness and per-digit blink, registered outputs.
module seg_led_ascii_mux #(
  parameter int DIGITS       = 6,
  parameter int DIV          = 16,
  parameter int SLOT_TICKS   = 1024,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                en,
  input  logic [8*DIGITS-1:0] chars,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blink,
  input  logic [3:0]          brightness,
  input  logic                load,
  output logic                busy,
  output logic                frame_start,
  output logic [DIGITS-1:0]   seg_sel,
  output logic [7:0]          seg_led
);
  localparam int PW = $clog2(DIV);
  localparam int SW = $clog2(SLOT_TICKS);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(DIV - 2);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_TICKS - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                first_q, first_d;
  logic                phase_q, phase_d;
  logic                busy_q, busy_d;
  logic                frame_start_q, frame_start_d;
  logic [8*DIGITS-1:0] pend_chars_q, pend_chars_d, disp_chars_q, disp_chars_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   pend_blink_q, pend_blink_d, disp_blink_q, disp_blink_d;
  logic [DIGITS-1:0]   seg_sel_q, seg_sel_d;
  logic [7:0]          seg_led_q, seg_led_d;

  logic       tick, frame_end, boundary, lit;
  logic [7:0] cur_char, cur_font;
  logic       cur_dp, cur_blink;

  function automatic logic [7:0] ascii_font(input logic [7:0] c);
    logic [7:0] f;
    case (c)
      8'h30: f = 8'hC0;
      8'h31: f = 8'hF9;
      8'h32: f = 8'hA4;
      8'h33: f = 8'hB0;
      8'h34: f = 8'h99;
      8'h35: f = 8'h92;
      8'h36: f = 8'h82;
      8'h37: f = 8'hF8;
      8'h38: f = 8'h80;
      8'h39: f = 8'h90;
      8'h41, 8'h61: f = 8'h88;
      8'h42, 8'h62: f = 8'h83;
      8'h43, 8'h63: f = 8'hC6;
      8'h44, 8'h64: f = 8'hA1;
      8'h45, 8'h65: f = 8'h86;
      8'h46, 8'h66: f = 8'h8E;
      8'h2D: f = 8'hBF;
      8'h5F: f = 8'hF7;
      8'h00, 8'h20: f = 8'hFF;
      default: f = 8'hB6;
    endcase
    return f;
  endfunction

  always_comb begin
    presc_d       = presc_q;
    slot_d        = slot_q;
    digit_d       = digit_q;
    fcnt_d        = fcnt_q;
    first_d       = first_q;
    phase_d       = phase_q;
    busy_d        = busy_q;
    pend_chars_d  = pend_chars_q;
    pend_dp_d     = pend_dp_q;
    pend_blink_d  = pend_blink_q;
    disp_chars_d  = disp_chars_q;
    disp_dp_d     = disp_dp_q;
    disp_blink_d  = disp_blink_q;
    cur_char      = 8'h00;
    cur_dp        = 1'b0;
    cur_blink     = 1'b0;

    tick      = (presc_q == PRESC_LAST);
    frame_end = (slot_q == SLOT_LAST) && (digit_q == DIGIT_LAST);
    boundary  = tick && (first_q || frame_end);
    // Counters only move on ticks, so the boundary can be predicted one cycle early.
    frame_start_d = (presc_q == PRESC_PRE) && (first_q || frame_end);

    presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick) begin
      slot_d  = slot_q + SW'(1);
      first_d = 1'b0;
      if (slot_q == SLOT_LAST)
        digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
    end

    if (boundary) begin
      disp_chars_d = pend_chars_q;
      disp_dp_d    = pend_dp_q;
      disp_blink_d = pend_blink_q;
      if (fcnt_q == FRAME_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    // A load in the boundary cycle lands in pending only and keeps busy set.
    if (load) begin
      pend_chars_d = chars;
      pend_dp_d    = dp;
      pend_blink_d = blink;
    end
    busy_d = load ? 1'b1 : (boundary ? 1'b0 : busy_q);

    for (int i = 0; i < DIGITS; i++) begin
      if (digit_q == DW'(i)) begin
        cur_char  = disp_chars_q[8*i +: 8];
        cur_dp    = disp_dp_q[i];
        cur_blink = disp_blink_q[i];
      end
    end
    cur_font = ascii_font(cur_char);
    lit = en && (slot_q[SW-1 -: 4] <= brightness) && !(cur_blink && phase_q);

    for (int i = 0; i < DIGITS; i++)
      seg_sel_d[i] = !(lit && (digit_q == DW'(i)));
    seg_led_d = lit ? {cur_font[7] & ~cur_dp, cur_font[6:0]} : 8'hFF;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      presc_q       <= '0;
      slot_q        <= '0;
      digit_q       <= '0;
      fcnt_q        <= '0;
      first_q       <= 1'b1;
      phase_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      pend_chars_q  <= '0;
      pend_dp_q     <= '0;
      pend_blink_q  <= '0;
      disp_chars_q  <= '0;
      disp_dp_q     <= '0;
      disp_blink_q  <= '0;
      seg_sel_q     <= '1;
      seg_led_q     <= 8'hFF;
    end else begin
      presc_q       <= presc_d;
      slot_q        <= slot_d;
      digit_q       <= digit_d;
      fcnt_q        <= fcnt_d;
      first_q       <= first_d;
      phase_q       <= phase_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
      pend_chars_q  <= pend_chars_d;
      pend_dp_q     <= pend_dp_d;
      pend_blink_q  <= pend_blink_d;
      disp_chars_q  <= disp_chars_d;
      disp_dp_q     <= disp_dp_d;
      disp_blink_q  <= disp_blink_d;
      seg_sel_q     <= seg_sel_d;
      seg_led_q     <= seg_led_d;
    end
  end

  assign busy        = busy_q;
  assign frame_start = frame_start_q;
  assign seg_sel     = seg_sel_q;
  assign seg_led     = seg_led_q;
endmodule

// File: tb/tb_seg_led_ascii_mux.sv
// Bench for seg_led_ascii_mux: directed scenarios plus a randomized phase, every
// cycle compared against a model derived from the cycle index since reset.
module tb_seg_led_ascii_mux;
  localparam int D     = 4;
  localparam int DIVP  = 2;
  localparam int S     = 16;
  localparam int BF    = 2;
  localparam int SD    = S * D;
  localparam int FRAME = SD * DIVP;
  localparam logic [7:0] DIG_FONT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [7:0] HEX_FONT [6]  = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst_n, en, load, busy, frame_start;
  logic [31:0] chars;
  logic [3:0]  dp, blink, brightness, seg_sel;
  logic [7:0]  seg_led;

  always #5 clk = ~clk;

  seg_led_ascii_mux #(.DIGITS(D), .DIV(DIVP), .SLOT_TICKS(S), .BLINK_FRAMES(BF)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .chars(chars), .dp(dp), .blink(blink),
    .brightness(brightness), .load(load), .busy(busy), .frame_start(frame_start),
    .seg_sel(seg_sel), .seg_led(seg_led));

  int checks = 0;
  int failures = 0;
  int mc = 0;
  logic        m_busy = 1'b0;
  logic [31:0] m_pend_chars = '0, m_disp_chars = '0;
  logic [3:0]  m_pend_dp = '0, m_disp_dp = '0, m_pend_blink = '0, m_disp_blink = '0;
  int lit_cnt [D];
  int val_cnt [D];
  logic [7:0] val_ref [D];
  int cnt_f8, cnt_notff;

  function automatic logic [7:0] ref_font(input logic [7:0] c);
    logic [7:0] lc;
    lc = c | 8'h20;
    if (c >= 8'h30 && c <= 8'h39) return DIG_FONT[int'(c) - 'h30];
    if (lc >= 8'h61 && lc <= 8'h66) return HEX_FONT[int'(lc) - 'h61];
    if (c == 8'h2D) return 8'hBF;
    if (c == 8'h5F) return 8'hF7;
    if (c == 8'h00 || c == 8'h20) return 8'hFF;
    return 8'hB6;
  endfunction

  // Boundaries: the first tick after reset, then the last tick of every frame.
  function automatic bit is_bnd(input int c);
    int t;
    t = c / DIVP;
    return (c % DIVP == DIVP - 1) && (t == 0 || t % SD == SD - 1);
  endfunction

  function automatic int phase_of(input int c);
    int t, nb;
    t  = c / DIVP;
    nb = ((t > 0) ? 1 : 0) + t / SD;
    return (nb / BF) % 2;
  endfunction

  function automatic logic [31:0] rand_chars();
    string pool;
    logic [31:0] r;
    pool = "0123456789AaBbCcDdEeFf-_ xQ";
    r = '0;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 3))
        0:       r[8*k +: 8] = 8'($urandom);
        1:       r[8*k +: 8] = 8'h00;
        default: r[8*k +: 8] = pool[$urandom_range(0, pool.len() - 1)];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, mc, obs, exp);
    end
  endtask

  task automatic clear_cnt();
    for (int k = 0; k < D; k++) begin
      lit_cnt[k] = 0;
      val_cnt[k] = 0;
    end
    cnt_f8 = 0;
    cnt_notff = 0;
  endtask

  task automatic step();
    logic [3:0] es, pat;
    logic [7:0] el;
    logic eb, ef, lit, b, r, ld;
    logic [31:0] ci;
    logic [3:0] di, bi;
    int t, slot, d;
    r = rst_n; ld = load; ci = chars; di = dp; bi = blink;
    b = 1'b0;
    if (!r) begin
      es = 4'hF; el = 8'hFF; eb = 1'b0; ef = 1'b0;
    end else begin
      t    = mc / DIVP;
      slot = t % S;
      d    = (t / S) % D;
      lit  = en && ((slot / (S / 16)) <= int'(brightness)) &&
             !(m_disp_blink[d] && phase_of(mc) == 1);
      es = 4'hF; el = 8'hFF;
      if (lit) begin
        es[d] = 1'b0;
        el = ref_font(m_disp_chars[8*d +: 8]);
        if (m_disp_dp[d]) el[7] = 1'b0;
      end
      b  = is_bnd(mc);
      eb = ld ? 1'b1 : (b ? 1'b0 : m_busy);
      ef = is_bnd(mc + 1);
    end
    @(posedge clk); #1;
    chk("seg_sel", 32'(seg_sel), 32'(es));
    chk("seg_led", 32'(seg_led), 32'(el));
    chk("busy", 32'(busy), 32'(eb));
    chk("frame_start", 32'(frame_start), 32'(ef));
    for (int k = 0; k < D; k++) begin
      pat = 4'hF; pat[k] = 1'b0;
      if (seg_sel[k] === 1'b0) lit_cnt[k]++;
      if (seg_sel === pat && seg_led === val_ref[k]) val_cnt[k]++;
    end
    if (seg_led === 8'hF8) cnt_f8++;
    if (seg_led !== 8'hFF) cnt_notff++;
    if (!r) begin
      mc = 0; m_busy = 1'b0;
      m_pend_chars = '0; m_disp_chars = '0;
      m_pend_dp = '0; m_disp_dp = '0; m_pend_blink = '0; m_disp_blink = '0;
    end else begin
      if (b) begin
        m_disp_chars = m_pend_chars; m_disp_dp = m_pend_dp; m_disp_blink = m_pend_blink;
      end
      if (ld) begin
        m_pend_chars = ci; m_pend_dp = di; m_pend_blink = bi;
      end
      m_busy = eb;
      mc++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_to_bnd();
    for (int k = 0; k < 2 * FRAME && !is_bnd(mc); k++) step();
  endtask

  task automatic do_load(input logic [31:0] c, input logic [3:0] p, input logic [3:0] bl);
    chars = c; dp = p; blink = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; chars = '0; dp = '0; blink = '0;
    brightness = 4'd15;
    for (int k = 0; k < D; k++) val_ref[k] = 8'h00;
    clear_cnt();
    run(3);
    chk("rst_sel", 32'(seg_sel), 32'hF);
    chk("rst_led", 32'(seg_led), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);

    // "1","A","-","x" with the decimal point on digit 0
    rst_n = 1'b1; en = 1'b1;
    run(5);
    do_load({8'h78, 8'h2D, 8'h41, 8'h31}, 4'b0001, 4'b0000);
    chk("load_busy", 32'(busy), 32'h1);
    val_ref[0] = 8'h79; val_ref[1] = 8'h88; val_ref[2] = 8'hBF; val_ref[3] = 8'hB6;
    run_to_bnd(); run(2);
    clear_cnt();
    run(FRAME);
    for (int k = 0; k < D; k++) begin
      chk($sformatf("font_digit%0d_cycles", k), val_cnt[k], 32);
      chk($sformatf("lit_full_digit%0d", k), lit_cnt[k], 32);
    end

    // brightness 3: 8 lit cycles per 32-cycle slot
    brightness = 4'd3;
    run(2); clear_cnt(); run(FRAME);
    for (int k = 0; k < D; k++) chk($sformatf("lit_b3_digit%0d", k), lit_cnt[k], 8);

    // two loads in one frame, third in the frame_start cycle
    brightness = 4'd15;
    run_to_bnd(); step();
    clear_cnt();
    do_load({4{8'h37}}, 4'b0000, 4'b0000);
    run(5);
    do_load({8'h32, 8'h33, 8'h34, 8'h35}, 4'b0000, 4'b0000);
    run_to_bnd();
    chk("bnd_frame_start", 32'(frame_start), 32'h1);
    do_load({8'h43, 8'h41, 8'h46, 8'h45}, 4'b0000, 4'b0000);
    chk("busy_after_bnd_load", 32'(busy), 32'h1);
    val_ref[0] = 8'h86; val_ref[1] = 8'h8E; val_ref[2] = 8'h88; val_ref[3] = 8'hC6;
    run_to_bnd(); run(2);
    for (int k = 0; k < D; k++) begin
      val_cnt[k] = 0;
    end
    run(FRAME);
    for (int k = 0; k < D; k++) chk($sformatf("latest_digit%0d_cycles", k), val_cnt[k], 32);
    chk("no_intermediate_data", cnt_f8, 0);

    // blink on digit 1 only
    do_load({8'h33, 8'h32, 8'h31, 8'h30}, 4'b0000, 4'b0010);
    run_to_bnd(); run(2);
    clear_cnt();
    run(4 * FRAME);
    chk("blink_digit1_lit", lit_cnt[1], 64);
    chk("blink_digit0_lit", lit_cnt[0], 128);
    chk("blink_digit2_lit", lit_cnt[2], 128);
    chk("blink_digit3_lit", lit_cnt[3], 128);

    // enable dropped mid-slot, then restored
    run(5);
    en = 1'b0;
    step();
    chk("en_off_sel", 32'(seg_sel), 32'hF);
    chk("en_off_led", 32'(seg_led), 32'hFF);
    run(20);
    en = 1'b1;
    run(40);

    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 39) == 0);
      if (load) begin
        chars = rand_chars(); dp = 4'($urandom); blink = 4'($urandom);
      end
      if ($urandom_range(0, 199) == 0) brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) en = ~en;
      step();
    end
    load = 1'b0; en = 1'b1; brightness = 4'd15;

    // reset mid-frame with a load pending
    run_to_bnd(); step();
    do_load(rand_chars() | 32'h0101_0101, 4'b1111, 4'b0000);
    run(3);
    chk("busy_before_reset", 32'(busy), 32'h1);
    rst_n = 1'b0;
    step();
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_sel", 32'(seg_sel), 32'hF);
    chk("reset_led", 32'(seg_led), 32'hFF);
    rst_n = 1'b1;
    clear_cnt();
    run(2 * FRAME);
    chk("blank_after_reset", cnt_notff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
